lcd_nibble_receiver: RTL and testbench

//  Receiving end of the HD44780 4-bit write bus driven by LcdController: samples lcd_rs/lcd_e/lcd_data,

---
 rtl/lcd_nibble_receiver.sv | 197 +++++++++++++++++++
 tb/tb_lcd_nibble_receiver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_receiver.sv
// HD44780 4-bit write-bus receiver that mirrors the 2x16 visible display into a 32-byte buffer.
// Optional nibble timeout: define LCD_RX_TIMEOUT_EN to drop a hi nibble left waiting TIMEOUT_CYC cycles.
module lcd_nibble_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic       Clk,
   input  logic       Re,
   input  logic       lcd_rs,
   input  logic       lcd_e,
   input  logic [3:0] lcd_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_char,
   output logic       byte_valid,
   output logic [7:0] byte_out,
   output logic       byte_rs,
   output logic [6:0] ddram_addr,
   output logic       clear_busy,
   output logic       err
);

   typedef enum logic {HI, LO} nib_state_t;

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   logic [SYNC_STAGES-1:0]      e_sync;
   logic [SYNC_STAGES-1:0]      rs_sync;
   logic [SYNC_STAGES-1:0][3:0] data_sync;
   logic                        e_prev;

   nib_state_t state;
   logic [3:0] hi_nib;
   logic       hi_rs;
   logic       fill_active;
   logic [4:0] fill_idx;
   logic [7:0] buffer [32];

   logic       e_fall;
   logic       cur_rs;
   logic [3:0] cur_data;
   logic       byte_done;
   logic       rs_mismatch;
   logic [7:0] new_byte;
   logic       cmd_addr;
   logic       cmd_clear;
   logic       data_write;
   logic       data_drop;
   logic       in_row0;
   logic       in_row1;
   logic       store_ok;
   logic [6:0] ddram_inc;
   logic       mem_we;
   logic [4:0] mem_idx;
   logic [7:0] mem_val;
   logic       timeout_hit;

   always_ff @(posedge Clk) begin
      if (Re) begin
         e_sync    <= '0;
         rs_sync   <= '0;
         data_sync <= '0;
         e_prev    <= 1'b0;
      end else begin
         e_sync    <= {e_sync[SYNC_STAGES-2:0], lcd_e};
         rs_sync   <= {rs_sync[SYNC_STAGES-2:0], lcd_rs};
         data_sync <= {data_sync[SYNC_STAGES-2:0], lcd_data};
         e_prev    <= e_sync[SYNC_STAGES-1];
      end
   end

   assign e_fall   = e_prev & ~e_sync[SYNC_STAGES-1];
   assign cur_rs   = rs_sync[SYNC_STAGES-1];
   assign cur_data = data_sync[SYNC_STAGES-1];

   assign byte_done   = (state == LO) && e_fall && (cur_rs == hi_rs);
   assign rs_mismatch = (state == LO) && e_fall && (cur_rs != hi_rs);
   assign new_byte    = {hi_nib, cur_data};
   assign cmd_addr    = byte_done && !hi_rs && new_byte[7];
   assign cmd_clear   = byte_done && !hi_rs && (new_byte == 8'h01);
   assign data_write  = byte_done && hi_rs && !fill_active;
   assign data_drop   = byte_done && hi_rs && fill_active;

   // Only DDRAM 0x00-0x0F and 0x40-0x4F are visible; other addresses still advance the counter.
   assign in_row0  = (ddram_addr[6:4] == 3'b000);
   assign in_row1  = (ddram_addr[6:4] == 3'b100);
   assign store_ok = data_write && (in_row0 || in_row1);
   assign ddram_inc = (ddram_addr == 7'h27) ? 7'h40 :
                      (ddram_addr == 7'h67) ? 7'h00 : ddram_addr + 7'd1;

   assign mem_we  = !Re && (fill_active || store_ok);
   assign mem_idx = fill_active ? fill_idx : {in_row1, ddram_addr[3:0]};
   assign mem_val = fill_active ? 8'h20 : new_byte;

`ifdef LCD_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] to_cnt;

   assign timeout_hit = (state == LO) && !e_fall && (to_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge Clk) begin
      if (Re) begin
         to_cnt <= '0;
      end else if (e_fall) begin
         to_cnt <= '0;
      end else if (state == LO && !timeout_hit) begin
         to_cnt <= to_cnt + TW'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // A mismatched lo nibble is kept as the new hi nibble, so the FSM stays in LO.
   always_ff @(posedge Clk) begin
      if (Re) begin
         state       <= HI;
         hi_nib      <= 4'h0;
         hi_rs       <= 1'b0;
         byte_valid  <= 1'b0;
         byte_out    <= 8'h00;
         byte_rs     <= 1'b0;
         ddram_addr  <= 7'h00;
         err         <= 1'b0;
         fill_active <= 1'b1;
         fill_idx    <= 5'd0;
      end else begin
         byte_valid <= byte_done;
         err        <= rs_mismatch | data_drop | timeout_hit;
         if (byte_done) begin
            byte_out <= new_byte;
            byte_rs  <= hi_rs;
         end

         case (state)
            HI: begin
               if (e_fall) begin
                  hi_nib <= cur_data;
                  hi_rs  <= cur_rs;
                  state  <= LO;
               end
            end
            LO: begin
               if (byte_done) begin
                  state <= HI;
               end else if (rs_mismatch) begin
                  hi_nib <= cur_data;
                  hi_rs  <= cur_rs;
               end else if (timeout_hit) begin
                  state <= HI;
               end
            end
            default: state <= HI;
         endcase

         if (cmd_clear) begin
            ddram_addr <= 7'h00;
         end else if (cmd_addr) begin
            ddram_addr <= new_byte[6:0];
         end else if (data_write) begin
            ddram_addr <= ddram_inc;
         end

         if (cmd_clear) begin
            fill_active <= 1'b1;
            fill_idx    <= 5'd0;
         end else if (fill_active) begin
            if (fill_idx == 5'd31) begin
               fill_active <= 1'b0;
            end
            fill_idx <= fill_idx + 5'd1;
         end
      end
   end

   assign clear_busy = fill_active;

   always_ff @(posedge Clk) begin
      if (mem_we) begin
         buffer[mem_idx] <= mem_val;
      end
   end

   // Registered read sees the old entry when a write to the same index lands on this edge.
   always_ff @(posedge Clk) begin
      if (Re) begin
         rd_char <= 8'h00;
      end else begin
         rd_char <= buffer[rd_addr];
      end
   end

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Scoreboard bench for lcd_nibble_receiver: drives the 4-bit LCD write bus and checks bytes, address and buffer.
module tb_lcd_nibble_receiver;

   logic       Clk = 1'b0;
   logic       Re = 1'b1;
   logic       lcd_rs = 1'b0;
   logic       lcd_e = 1'b0;
   logic [3:0] lcd_data = 4'h0;
   logic [4:0] rd_addr = 5'd0;
   logic [7:0] rd_char;
   logic       byte_valid;
   logic [7:0] byte_out;
   logic       byte_rs;
   logic [6:0] ddram_addr;
   logic       clear_busy;
   logic       err;

   int checks = 0;
   int failures = 0;
   int err_pulses = 0;
   int valid_pulses = 0;
   int err_base;
   int valid_base;
   int busy_cycles;
   logic [8:0] sb [$];
   logic [7:0] exp_buf [32];

   always #5 Clk = ~Clk;

   lcd_nibble_receiver dut (
      .Clk        (Clk),
      .Re         (Re),
      .lcd_rs     (lcd_rs),
      .lcd_e      (lcd_e),
      .lcd_data   (lcd_data),
      .rd_addr    (rd_addr),
      .rd_char    (rd_char),
      .byte_valid (byte_valid),
      .byte_out   (byte_out),
      .byte_rs    (byte_rs),
      .ddram_addr (ddram_addr),
      .clear_busy (clear_busy),
      .err        (err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #2;
   endtask

   task automatic send_nibble(input logic rs, input logic [3:0] nib);
      lcd_rs   = rs;
      lcd_data = nib;
      lcd_e    = 1'b1;
      tick(2);
      lcd_e = 1'b0;
      tick(2);
   endtask

   task automatic applyStimulus(input logic rs, input logic [7:0] b);
      sb.push_back({rs, b});
      send_nibble(rs, b[7:4]);
      send_nibble(rs, b[3:0]);
      tick(6);
   endtask

   task automatic check_ddram(input string tag, input logic [6:0] exp);
      @(negedge Clk);
      checkOutput(tag, 32'(ddram_addr), 32'(exp));
      tick(1);
   endtask

   task automatic check_buffer(input string tag);
      for (int i = 0; i < 32; i++) begin
         rd_addr = 5'(i);
         @(posedge Clk);
         @(negedge Clk);
         checkOutput($sformatf("%s[%0d]", tag, i), 32'(rd_char), 32'(exp_buf[i]));
      end
      tick(1);
   endtask

   task automatic wait_fill(output int cycles);
      cycles = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge Clk);
         if (!clear_busy) break;
         cycles++;
      end
      tick(1);
   endtask

   // Every assembled byte must match the oldest byte the stimulus promised.
   always @(negedge Clk) begin
      if (err) err_pulses++;
      if (byte_valid) begin
         valid_pulses++;
         if (sb.size() == 0) begin
            checkOutput("unexpected_byte", 32'({byte_rs, byte_out}), 32'hFFFF_FFFF);
         end else begin
            checkOutput("byte", 32'({byte_rs, byte_out}), 32'(sb.pop_front()));
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;

      tick(3);
      @(negedge Clk);
      checkOutput("rst_ddram", 32'(ddram_addr), 32'h0);
      checkOutput("rst_valid", 32'(byte_valid), 32'h0);
      checkOutput("rst_err", 32'(err), 32'h0);
      checkOutput("rst_rdchar", 32'(rd_char), 32'h0);
      checkOutput("rst_byte", 32'({byte_rs, byte_out}), 32'h0);
      tick(1);
      Re = 1'b0;
      wait_fill(busy_cycles);
      checkOutput("fill_len", 32'(busy_cycles), 32'd32);
      check_buffer("init_buf");

      valid_base = valid_pulses;
      applyStimulus(1'b0, 8'hC0);
      applyStimulus(1'b1, 8'h41);
      applyStimulus(1'b1, 8'h42);
      exp_buf[16] = 8'h41;
      exp_buf[17] = 8'h42;
      checkOutput("row1_valid_cnt", 32'(valid_pulses - valid_base), 32'd3);
      check_ddram("row1_ddram", 7'h42);

      applyStimulus(1'b0, 8'hA7);
      applyStimulus(1'b1, 8'h58);
      check_ddram("wrap_27", 7'h40);
      applyStimulus(1'b0, 8'hE7);
      applyStimulus(1'b1, 8'h58);
      check_ddram("wrap_67", 7'h00);
      applyStimulus(1'b0, 8'h8F);
      applyStimulus(1'b1, 8'h5A);
      exp_buf[15] = 8'h5A;
      check_ddram("row0_end", 7'h10);
      applyStimulus(1'b1, 8'h5B);
      check_ddram("offscreen", 7'h11);
      check_buffer("write_buf");

      err_base   = err_pulses;
      valid_base = valid_pulses;
      send_nibble(1'b1, 4'h4);
      send_nibble(1'b0, 4'h8);
      sb.push_back({1'b0, 8'h81});
      send_nibble(1'b0, 4'h1);
      tick(6);
      checkOutput("rs_mis_err", 32'(err_pulses - err_base), 32'd1);
      checkOutput("rs_mis_valid", 32'(valid_pulses - valid_base), 32'd1);
      check_ddram("rs_mis_ddram", 7'h01);

      err_base = err_pulses;
      applyStimulus(1'b0, 8'h01);
      applyStimulus(1'b1, 8'h31);
      for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
      wait_fill(busy_cycles);
      checkOutput("fill_drop_err", 32'(err_pulses - err_base), 32'd1);
      check_ddram("clear_ddram", 7'h00);
      check_buffer("clear_buf");

      err_base = err_pulses;
`ifdef LCD_RX_TIMEOUT_EN
      send_nibble(1'b0, 4'h8);
      tick(70);
      checkOutput("timeout_err", 32'(err_pulses - err_base), 32'd1);
      applyStimulus(1'b0, 8'h85);
`else
      sb.push_back({1'b0, 8'h85});
      send_nibble(1'b0, 4'h8);
      tick(80);
      send_nibble(1'b0, 4'h5);
      tick(6);
      checkOutput("no_timeout_err", 32'(err_pulses - err_base), 32'd0);
`endif
      check_ddram("idle_ddram", 7'h05);

      send_nibble(1'b0, 4'h9);
      Re = 1'b1;
      tick(2);
      Re = 1'b0;
      wait_fill(busy_cycles);
      checkOutput("refill_len", 32'(busy_cycles), 32'd32);
      check_ddram("rst_mid_ddram", 7'h00);
      applyStimulus(1'b0, 8'h83);
      check_ddram("after_rst_ddram", 7'h03);
      check_buffer("after_rst_buf");

      checkOutput("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
